// File: rtl/sha256_preprocessor_pkg.sv
// Shared constants and FSM state type for the SHA-256 preprocessor (package sha_pkg).
// The PREPROC_ONECYCLE_SCAN_EN build option is selected in msg_len_finder and sha256_preprocessor.
package sha_pkg;
    localparam int MSG_W     = 440;
    localparam int BLK_W     = 512;
    localparam int LEN_W     = 64;
    localparam int MSG_BYTES = 55;
    localparam int CNT_W     = 6;

    localparam logic [7:0] PAD_MARKER = 8'h80;

    typedef enum logic [1:0] {
        IDLE,
        SCAN,
        PAD,
        DONE
    } stateT;
endpackage

// File: rtl/msg_len_finder.sv
// Finds the message byte length L and left-justifies the message.
// PREPROC_ONECYCLE_SCAN_EN selects a one-cycle priority encoder instead of the byte-serial scan.
module msg_len_finder
    import sha_pkg::*;
(
    input  logic             clk,
    input  logic             n_rst,
    input  logic             load,
    input  logic             scanEn,
    input  logic [MSG_W-1:0] msgIn,
    output logic             found,
    output logic [CNT_W-1:0] len,
    output logic [MSG_W-1:0] justified
);

`ifdef PREPROC_ONECYCLE_SCAN_EN
    logic [MSG_W-1:0] msgReg;
    logic [CNT_W-1:0] gap;
    logic [8:0]       shAmt;
    logic             scanUnused;

    always_ff @(posedge clk or posedge n_rst) begin
        if (n_rst) begin
            msgReg <= '0;
        end else if (load) begin
            msgReg <= msgIn;
        end
    end

    // Highest non-zero byte wins; an all-zero message yields L=0.
    always_comb begin
        len = '0;
        for (int i = 0; i < MSG_BYTES; i++) begin
            if (msgReg[8*i +: 8] != 8'h00) begin
                len = CNT_W'(i + 1);
            end
        end
    end

    assign gap        = CNT_W'(MSG_BYTES) - len;
    assign shAmt      = {gap, 3'b000};
    assign justified  = msgReg << shAmt;
    assign found      = 1'b1;
    assign scanUnused = scanEn;
`else
    logic [MSG_W-1:0] shreg;
    logic [CNT_W-1:0] count;

    // Stop once the leading byte is non-zero or every byte has been shifted out.
    assign found = (shreg[MSG_W-1 -: 8] != 8'h00) || (count == '0);

    always_ff @(posedge clk or posedge n_rst) begin
        if (n_rst) begin
            shreg <= '0;
            count <= '0;
        end else if (load) begin
            shreg <= msgIn;
            count <= CNT_W'(MSG_BYTES);
        end else if (scanEn && !found) begin
            shreg <= {shreg[MSG_W-9:0], 8'h00};
            count <= count - 1'b1;
        end
    end

    assign len       = count;
    assign justified = shreg;
`endif

endmodule

// File: rtl/sha256_preprocessor.sv
// Builds the single padded SHA-256 block from a right-justified message of up to 55 bytes.
// PREPROC_ONECYCLE_SCAN_EN skips the SCAN state and pads on the cycle after start.
module sha256_preprocessor
    import sha_pkg::*;
(
    input  logic             clk,
    input  logic             n_rst,
    input  logic [MSG_W-1:0] inputMsg,
    input  logic             beginPreprocess,
    output logic [BLK_W-1:0] processedMsg,
    output logic             done
);

    stateT            state;
    stateT            nextState;
    logic             load;
    logic             scanEn;
    logic             padEn;
    logic             found;
    logic [CNT_W-1:0] len;
    logic [MSG_W-1:0] justified;
    logic [8:0]       markerShift;
    logic [LEN_W-1:0] lenBits;
    logic [BLK_W-1:0] blockNext;

`ifdef PREPROC_ONECYCLE_SCAN_EN
    localparam stateT AFTER_START = PAD;
`else
    localparam stateT AFTER_START = SCAN;
`endif

    msg_len_finder u_finder (
        .clk       (clk),
        .n_rst     (n_rst),
        .load      (load),
        .scanEn    (scanEn),
        .msgIn     (inputMsg),
        .found     (found),
        .len       (len),
        .justified (justified)
    );

    always_ff @(posedge clk or posedge n_rst) begin
        if (n_rst) begin
            state <= IDLE;
        end else begin
            state <= nextState;
        end
    end

    always_comb begin
        nextState = state;
        load      = 1'b0;
        scanEn    = 1'b0;
        padEn     = 1'b0;
        case (state)
            IDLE, DONE: begin
                if (beginPreprocess) begin
                    load      = 1'b1;
                    nextState = AFTER_START;
                end
            end
            SCAN: begin
                scanEn = 1'b1;
                if (found) begin
                    nextState = PAD;
                end
            end
            PAD: begin
                padEn     = 1'b1;
                nextState = DONE;
            end
            default: nextState = IDLE;
        endcase
    end

    // Marker lands on byte L counted from the MSB, directly after the message.
    assign markerShift = 9'(BLK_W - 8) - {len, 3'b000};
    assign lenBits     = LEN_W'({len, 3'b000});
    assign blockNext   = {justified, {(BLK_W-MSG_W){1'b0}}}
                       | ({{(BLK_W-8){1'b0}}, PAD_MARKER} << markerShift)
                       | {{(BLK_W-LEN_W){1'b0}}, lenBits};

    always_ff @(posedge clk or posedge n_rst) begin
        if (n_rst) begin
            processedMsg <= '0;
        end else if (padEn) begin
            processedMsg <= blockNext;
        end
    end

    assign done = (state == DONE);

endmodule

// File: tb/tb_sha256_preprocessor.sv
// Directed bench for sha256_preprocessor with an expected-block scoreboard.
module tb_sha256_preprocessor;

    logic         clk = 1'b0;
    logic         n_rst = 1'b1;
    logic [439:0] inputMsg = '0;
    logic         beginPreprocess = 1'b0;
    logic [511:0] processedMsg;
    logic         done;

    int           errors = 0;
    int           checks = 0;
    logic [511:0] sbQ[$];
    logic [511:0] lastExp = '0;
    logic [511:0] e;
    logic [439:0] m;
    int           lat;

    sha256_preprocessor dut (
        .clk             (clk),
        .n_rst           (n_rst),
        .inputMsg        (inputMsg),
        .beginPreprocess (beginPreprocess),
        .processedMsg    (processedMsg),
        .done            (done)
    );

    always #5 clk = ~clk;

    function automatic int lenOf(input logic [439:0] msg);
        int l = 0;
        for (int i = 0; i < 55; i++)
            if (msg[8*i +: 8] != 8'h00) l = i + 1;
        return l;
    endfunction

    // Byte-by-byte reference: message bytes in order, then marker, then bit length.
    function automatic logic [511:0] model(input logic [439:0] msg);
        int l = lenOf(msg);
        logic [511:0] b = '0;
        for (int k = 0; k < l; k++)
            b[511-8*k -: 8] = msg[8*(l-1-k) +: 8];
        b[511-8*l -: 8] = 8'h80;
        b[63:0] = 64'(l * 8);
        return b;
    endfunction

    function automatic int expLat(input logic [439:0] msg);
`ifdef PREPROC_ONECYCLE_SCAN_EN
        return 2;
`else
        return 58 - lenOf(msg);
`endif
    endfunction

    function automatic logic [439:0] randMsg(input int l);
        logic [439:0] r = '0;
        for (int i = 0; i < l; i++) r[8*i +: 8] = 8'($urandom_range(0, 255));
        if (l > 0) r[8*(l-1) +: 8] = 8'($urandom_range(1, 255));
        return r;
    endfunction

    task automatic chk(input string tag, input logic [511:0] got, input logic [511:0] want);
        checks++;
        assert (got === want) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, want);
        end
    endtask

    // Drive a start; on the start edge done must fall and the old block must still be held.
    task automatic startRun(input logic [439:0] msg, input logic [511:0] want);
        @(negedge clk);
        inputMsg = msg;
        beginPreprocess = 1'b1;
        sbQ.push_back(want);
        @(posedge clk);
        #1;
        beginPreprocess = 1'b0;
        chk("done_falls_on_start", 512'(done), 512'd0);
        chk("block_held_on_start", processedMsg, lastExp);
    endtask

    task automatic waitDone(input int lat0, output int latOut);
        latOut = lat0;
        while (!done && latOut < 100) begin
            @(posedge clk);
            #1;
            latOut++;
        end
    endtask

    task automatic finishRun(input string tag, input int wantLat);
        logic [511:0] want;
        chk({tag, "_done"}, 512'(done), 512'd1);
        chk({tag, "_latency"}, 512'(lat), 512'(wantLat));
        want = (sbQ.size() > 0) ? sbQ.pop_front() : '0;
        chk({tag, "_block"}, processedMsg, want);
        lastExp = want;
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        chk("reset_done", 512'(done), 512'd0);
        chk("reset_block", processedMsg, 512'd0);
        @(negedge clk);
        n_rst = 1'b0;

        // 'a'
        m = 440'd97;
        e = '0; e[511:496] = 16'h6180; e[63:0] = 64'd8;
        startRun(m, e); waitDone(1, lat); finishRun("a", expLat(m));

        // "abc"
        m = 440'h616263;
        e = '0; e[511:480] = 32'h61626380; e[63:0] = 64'h18;
        startRun(m, e); waitDone(1, lat); finishRun("abc", expLat(m));

        // empty message: worst-case latency
        m = '0;
        e = '0; e[511:504] = 8'h80;
        startRun(m, e); waitDone(1, lat); finishRun("empty", expLat(m));

        // full 55-byte message
        m = randMsg(55); m[439:432] = 8'h01;
        e = '0; e[511:72] = m; e[71:64] = 8'h80; e[63:0] = 64'h1B8;
        startRun(m, e); waitDone(1, lat); finishRun("full55", expLat(m));

        // hold: done and block stay put while idle in DONE
        repeat (5) @(posedge clk);
        #1;
        chk("hold_done", 512'(done), 512'd1);
        chk("hold_block", processedMsg, lastExp);

        // second start while busy must be ignored
        m = 440'd97;
        startRun(m, model(m));
        beginPreprocess = 1'b1;
        inputMsg = randMsg(30);
        @(posedge clk);
        #1;
        beginPreprocess = 1'b0;
        waitDone(2, lat); finishRun("ignore_busy", expLat(m));

        // restart from DONE with a different message
        m = randMsg(20);
        startRun(m, model(m)); waitDone(1, lat); finishRun("restart", expLat(m));

        // async reset during an operation
        m = '0;
        startRun(m, model(m));
        repeat (4) @(posedge clk);
        #2;
        n_rst = 1'b1;
        #1;
        chk("midreset_done", 512'(done), 512'd0);
        chk("midreset_block", processedMsg, 512'd0);
        void'(sbQ.pop_front());
        lastExp = '0;
        @(negedge clk);
        n_rst = 1'b0;

        m = 440'h616263;
        startRun(m, model(m)); waitDone(1, lat); finishRun("after_reset", expLat(m));

        // assorted lengths
        for (int l = 2; l < 55; l += 13) begin
            m = randMsg(l);
            startRun(m, model(m)); waitDone(1, lat); finishRun("rand", expLat(m));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
